// File: rtl/fib_age_arb_pkg.sv
// Shared FIB table geometry: address/entry widths, sweep depth and the age field placement.
package fib_age_arb_pkg;
  localparam int FIB_ASZ      = 8;
  localparam int FIB_ENTRIES  = 256;
  localparam int FIB_ENTRY_SZ = 64;
  localparam int FIB_AGE_LO   = 60;
  localparam int FIB_AGE_HI   = 63;
  localparam int FIB_AGE_W    = FIB_AGE_HI - FIB_AGE_LO + 1;
  localparam int FIB_MAX_AGE  = (1 << FIB_AGE_W) - 1;
endpackage

// File: rtl/fib_age_arb.sv
// FIB RAM port owner: lookup accesses take strict priority; a background sweeper
// decrements non-zero entry ages with read-modify-write on idle port cycles.
module fib_age_arb
  import fib_age_arb_pkg::*;
#(
  parameter int ASZ     = FIB_ASZ,
  parameter int ENTRIES = FIB_ENTRIES,
  parameter int ESZ     = FIB_ENTRY_SZ,
  parameter int AGE_LO  = FIB_AGE_LO,
  parameter int AGE_W   = FIB_AGE_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           lk_rd_en,
  input  logic           lk_wr_en,
  input  logic [ASZ-1:0] lk_addr,
  input  logic [ESZ-1:0] lk_wdata,
  output logic [ESZ-1:0] lk_rdata,
  input  logic           age_tick,
  output logic           age_busy,
  output logic           age_done,
  output logic           age_overrun,
  output logic           ft_rd_en,
  output logic           ft_wr_en,
  output logic [ASZ-1:0] ft_addr,
  output logic [ESZ-1:0] ft_wdata,
  input  logic [ESZ-1:0] ft_rdata
);

  localparam logic [3:0] IDLE = 4'b0001;
  localparam logic [3:0] RD   = 4'b0010;
  localparam logic [3:0] MOD  = 4'b0100;
  localparam logic [3:0] WB   = 4'b1000;
  localparam logic [ASZ-1:0] LAST = ASZ'(ENTRIES - 1);

  logic [3:0]       state;
  logic [3:0]       state_nxt;
  logic [ASZ-1:0]   ctr;
  logic             pend;
  logic [ESZ-1:0]   hold;
  logic             age_done_q;
  logic             age_overrun_q;
  logic             port_free;
  logic             last;
  logic             hazard;
  logic             start;
  logic             sw_adv;
  logic             sw_rd;
  logic             sw_wr;
  logic [AGE_W-1:0] age_in;

  // Reset also withholds the port so an in-flight write-back is never issued.
  assign port_free = ~(lk_rd_en | lk_wr_en) & ~reset;
  assign age_in    = ft_rdata[AGE_LO +: AGE_W];
  assign last      = (ctr == LAST);
  assign hazard    = lk_wr_en & (lk_addr == ctr) & (state[2] | state[3]);
  assign start     = state[0] & age_tick & ~age_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sw_adv    = 1'b0;
    if (state[0]) begin
      if (start) state_nxt = RD;
    end else if (state[1]) begin
      if (port_free) state_nxt = MOD;
    end else if (state[2]) begin
      state_nxt = WB;
    end else if (state[3]) begin
      if (!pend || port_free) begin
        sw_adv    = 1'b1;
        state_nxt = last ? IDLE : RD;
      end
    end
  end

  always_comb begin
    sw_rd    = state[1] & port_free;
    sw_wr    = state[3] & pend & port_free;
    age_busy = ~state[0] & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr           <= '0;
      pend          <= 1'b0;
      age_done_q    <= 1'b0;
      age_overrun_q <= 1'b0;
    end else begin
      age_done_q    <= sw_adv & last;
      // A tick in the age_done cycle is treated as arriving during the sweep.
      age_overrun_q <= age_tick & (~state[0] | age_done_q);
      if (start) begin
        ctr <= '0;
      end else if (sw_adv && !last) begin
        ctr <= ctr + 1'b1;
      end
      if (state[2]) begin
        pend <= (age_in != '0) & ~hazard;
      end else if (state[3] && hazard) begin
        pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state[2]) begin
      hold                   <= ft_rdata;
      hold[AGE_LO +: AGE_W]  <= age_in - AGE_W'(1);
    end
  end

  always_comb begin
    ft_rd_en = lk_rd_en;
    ft_wr_en = lk_wr_en;
    ft_addr  = lk_addr;
    ft_wdata = lk_wdata;
    if (sw_rd) begin
      ft_rd_en = 1'b1;
      ft_addr  = ctr;
    end else if (sw_wr) begin
      ft_wr_en = 1'b1;
      ft_addr  = ctr;
      ft_wdata = hold;
    end
  end

  assign lk_rdata    = ft_rdata;
  assign age_done    = age_done_q;
  assign age_overrun = age_overrun_q;

endmodule
